// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, frame constants
// and the clock-to-baud divider helper.
package uart_pkg;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Cycles per bit period; integer divide, so the line rate rounds up slightly.
   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte queue with free-wrapping pointers and an occupancy counter.
// Pushes while full are ignored even when a pop happens on the same edge.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; the pointers and count
   // alone decide which entries are valid, so clearing them empties the queue.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state is assigned with <= only, so every register here
   // sees the pre-edge values of its neighbours regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/buffered_uart_tx.sv
// FIFO-buffered UART transmitter: queued bytes leave back-to-back as 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module buffered_uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE     = 9600,
   parameter int FIFO_DEPTH    = 16,
   parameter int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             dout,
   output logic             busy,
   output logic [CNT_W-1:0] fill,
   output logic             overflow
);

   localparam int BAUD_DIV = baud_div(CLK_FREQUENCY, BAUD_RATE);
   localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BIT_W    = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   tx_state_t            state_q;
   tx_state_t            state_d;
   logic [BAUD_W-1:0]    baud_q;
   logic [BAUD_W-1:0]    baud_d;
   logic [BIT_W-1:0]     bit_q;
   logic [BIT_W-1:0]     bit_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic                 dout_q;
   logic                 dout_d;
   logic                 overflow_q;
   logic                 baud_end;

   logic                 fifo_pop;
   logic [7:0]           fifo_head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;

   byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_valid),
      .push_data (tx_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign baud_end = (baud_q == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         dout_q     <= IDLE_LEVEL;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         if (tx_valid && fifo_full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;

      // The divider only runs inside a frame, so timing is anchored to the pop.
      if (state_q != IDLE) begin
         baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_head;
               baud_d   = '0;
               state_d  = START;
            end
         end
         START: begin
            if (baud_end) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_end) begin
               if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_end) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (baud_end) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_head;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Line level is decoded from the next state so the registered pin changes
   // on the same edge as the state it belongs to.
   always_comb begin
      dout_d = IDLE_LEVEL;
      case (state_d)
         START:   dout_d = 1'b0;
         DATA:    dout_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
         PARITY:  dout_d = ^shift_d;
`endif
         default: dout_d = IDLE_LEVEL;
      endcase
   end

   assign tx_ready = !fifo_full;
   assign dout     = dout_q;
   assign busy     = (state_q != IDLE);
   assign fill     = fifo_count;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_buffered_uart_tx.sv
// Self-checking bench for buffered_uart_tx: a scoreboard queue of accepted bytes
// is compared against frames decoded cycle by cycle from the serial line.
module tb_buffered_uart_tx;

   localparam int CLK_HZ   = 400;
   localparam int BAUD     = 100;
   localparam int DEPTH    = 16;
   localparam int CNT_W    = 5;
   localparam int BIT_CYC  = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS    = 11;
`else
   localparam int NBITS    = 10;
`endif
   localparam int WAIT_MAX = 200;

   logic             clk      = 1'b0;
   logic             rst      = 1'b1;
   logic [7:0]       tx_data  = 8'h00;
   logic             tx_valid = 1'b0;
   logic             tx_ready;
   logic             dout;
   logic             busy;
   logic [CNT_W-1:0] fill;
   logic             overflow;

   int         cyc      = 0;
   int         errors   = 0;
   int         checks   = 0;
   int         accepted = 0;
   int         rejected = 0;
   logic [7:0] exp_q[$];

   buffered_uart_tx #(
      .CLK_FREQUENCY (CLK_HZ),
      .BAUD_RATE     (BAUD),
      .FIFO_DEPTH    (DEPTH),
      .CNT_W         (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .dout     (dout),
      .busy     (busy),
      .fill     (fill),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected line levels of one frame, index 0 = start bit.
   function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
      logic [NBITS-1:0] f;
      int ones;
      ones = 0;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = b[i];
         ones  += int'(b[i]);
      end
`ifdef UART_TX_PARITY_EN
      f[9] = 1'(ones % 2);
`endif
      return f;
   endfunction

   // Waits for a start bit, then checks every cycle of the frame against the
   // head of the scoreboard. Returns with the last stop-bit cycle just sampled.
   task automatic receive_frame(output int start_cyc, output int fill_first, output int fill_last);
      logic [7:0]         exp_b;
      logic [NBITS-1:0]   fb;
      logic [BIT_CYC-1:0] s;
      logic               busy_ok;
      int                 waited;
      start_cyc  = -1;
      fill_first = -1;
      fill_last  = -1;
      waited     = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (dout !== 1'b0 && waited < WAIT_MAX);
      check("start_bit_seen", 32'(dout), 32'd0);
      if (dout !== 1'b0) return;
      start_cyc  = cyc;
      fill_first = int'(fill);
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      exp_b   = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      fb      = frame_bits(exp_b);
      busy_ok = 1'b1;
      for (int b = 0; b < NBITS; b++) begin
         for (int k = 0; k < BIT_CYC; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            s[k]    = dout;
            busy_ok = busy_ok & busy;
         end
         check($sformatf("frame_%02h_bit%0d", exp_b, b), 32'(s), 32'({BIT_CYC{fb[b]}}));
      end
      check($sformatf("frame_%02h_busy", exp_b), 32'(busy_ok), 32'd1);
      fill_last = int'(fill);
   endtask

   task automatic send_byte(input logic [7:0] b, output int wr_cyc);
      int n;
      n = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      check("ready_for_write", 32'(tx_ready), 32'd1);
      wr_cyc = cyc;
      if (tx_ready === 1'b1) begin
         tx_valid = 1'b1;
         tx_data  = b;
         exp_q.push_back(b);
         @(posedge clk);
         #1 tx_valid = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, f0, fl0, t1, f1, fl1, wc;

      // Reset values while rst is still held
      repeat (3) @(negedge clk);
      check("reset_dout", 32'(dout), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_ready", 32'(tx_ready), 32'd1);
      check("reset_fill", 32'(fill), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;

      // Idle line: {dout,busy,tx_ready,overflow,fill} = 1,0,1,0,0
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("idle_outputs", 32'({dout, busy, tx_ready, overflow, fill}), 32'h140);
      end

      // Single byte into an idle block
      send_byte(8'hA5, wc);
      @(negedge clk);
      check("pre_pop_dout", 32'(dout), 32'd1);
      check("pre_pop_busy", 32'(busy), 32'd0);
      check("pre_pop_fill", 32'(fill), 32'd1);
      receive_frame(t0, f0, fl0);
      check("start_latency", 32'(t0 - wc), 32'd2);
      check("fill_during_frame", 32'(f0), 32'd0);
      @(negedge clk);
      check("post_frame_busy", 32'(busy), 32'd0);
      check("post_frame_dout", 32'(dout), 32'd1);

      // Two bytes on consecutive cycles: second frame follows with no gap
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      exp_q.push_back(8'h00);
      @(negedge clk);
      tx_data = 8'hFF;
      exp_q.push_back(8'hFF);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      receive_frame(t0, f0, fl0);
      receive_frame(t1, f1, fl1);
      check("b2b_start_spacing", 32'(t1 - t0), 32'(NBITS * BIT_CYC));
      check("fill_before_pop2", 32'(fl0), 32'd1);
      check("fill_after_pop2", 32'(f1), 32'd0);
      @(negedge clk);
      check("b2b_busy_end", 32'(busy), 32'd0);

      // Hold tx_valid for 20 cycles: fill the queue and overflow it
      accepted = 0;
      rejected = 0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (rejected == 1) check("overflow_after_reject", 32'(overflow), 32'd1);
               if (tx_ready === 1'b1) begin
                  tx_data  = 8'($urandom);
                  tx_valid = 1'b1;
                  exp_q.push_back(tx_data);
                  accepted++;
               end else begin
                  if (rejected == 0) begin
                     check("overflow_before_reject", 32'(overflow), 32'd0);
                     check("fill_when_full", 32'(fill), 32'(DEPTH));
                  end
                  tx_valid = 1'b1;
                  rejected++;
               end
            end
            @(negedge clk);
            tx_valid = 1'b0;
         end
         begin
            for (int i = 0; i < DEPTH + 1; i++) receive_frame(t0, f0, fl0);
         end
      join
      check("accepted_count", 32'(accepted), 32'(DEPTH + 1));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check("burst_busy_end", 32'(busy), 32'd0);

      // Reset 10 cycles into a frame with one byte still queued
      send_byte(8'h3C, wc);
      send_byte(8'h81, wc);
      repeat (10) @(negedge clk);
      check("mid_frame_busy", 32'(busy), 32'd1);
      check("mid_frame_fill", 32'(fill), 32'd1);
      check("overflow_sticky", 32'(overflow), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_dout", 32'(dout), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_fill", 32'(fill), 32'd0);
      check("abort_overflow", 32'(overflow), 32'd0);
      check("abort_ready", 32'(tx_ready), 32'd1);
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         check("post_reset_quiet", 32'({dout, busy}), 32'h2);
      end

      // Random bytes with random gaps
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               repeat ($urandom_range(0, 45)) @(negedge clk);
               send_byte(8'($urandom), wc);
            end
         end
         begin
            for (int i = 0; i < 8; i++) receive_frame(t1, f1, fl1);
         end
      join
      check("random_queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef UART_TX_PARITY_EN
      // Even parity: 0x07 has three ones, 0x03 has two
      send_byte(8'h07, wc);
      receive_frame(t0, f0, fl0);
      @(negedge clk);
      check("parity07_frame_end", 32'(busy), 32'd0);
      send_byte(8'h03, wc);
      receive_frame(t0, f0, fl0);
      @(negedge clk);
      check("parity03_frame_end", 32'(busy), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
